// File: rtl/sprite_overlay.sv
// Composites one bouncing 16x16 2bpp sprite over the background pixel stream.
// Next line's sprite row is fetched in the line tail and swapped in at line end.
module sprite_overlay #(
  parameter int          VIDEO_X_BITWIDTH = 12,
  parameter int          VIDEO_Y_BITWIDTH = 11,
  parameter int          SCREEN_W         = 640,
  parameter int          SCREEN_H         = 480,
  parameter int          INIT_X           = 100,
  parameter int          INIT_Y           = 50,
  parameter logic [23:0] PAL1             = 24'hFF0000,
  parameter logic [23:0] PAL2             = 24'h00FF00,
  parameter logic [23:0] PAL3             = 24'hFFFFFF
) (
  input  logic                        I_clk_pixel,
  input  logic                        I_reset_n,
  input  logic [VIDEO_X_BITWIDTH-1:0] I_pixX,
  input  logic [VIDEO_Y_BITWIDTH-1:0] I_pixY,
  input  logic [VIDEO_X_BITWIDTH-1:0] I_frameWidth,
  input  logic [VIDEO_Y_BITWIDTH-1:0] I_frameHeight,
  input  logic [23:0]                 I_rgb,
  input  logic                        I_wr_en,
  input  logic [3:0]                  I_wr_row,
  input  logic [31:0]                 I_wr_data,
  output logic [23:0]                 O_rgb
);

  localparam int XW    = VIDEO_X_BITWIDTH;
  localparam int YW    = VIDEO_Y_BITWIDTH;
  localparam int MAX_X = SCREEN_W - 16;
  localparam int MAX_Y = SCREEN_H - 16;

  localparam logic [XW-1:0] X0   = XW'(MAX_X < 0 ? 0 : INIT_X);
  localparam logic [YW-1:0] Y0   = YW'(MAX_Y < 0 ? 0 : INIT_Y);
  localparam logic [XW-1:0] XLIM = XW'(MAX_X < 0 ? 0 : MAX_X);
  localparam logic [YW-1:0] YLIM = YW'(MAX_Y < 0 ? 0 : MAX_Y);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    LOAD
  } fetch_e;

  logic [31:0]   bitmap [16];
  logic [31:0]   rd_data;

  logic [XW-1:0] pos_x, pos_x_nxt;
  logic [YW-1:0] pos_y, pos_y_nxt;
  logic          neg_x, neg_x_nxt;
  logic          neg_y, neg_y_nxt;
  logic          last_line;
  logic          frame_end;

  fetch_e        state, state_nxt;
  logic [YW-1:0] next_y;
  logic [YW-1:0] row_off;
  logic          in_rng;
  logic          fetch_go;
  logic          line_end;

  logic [31:0]   bits_nxt, line_bits;
  logic [XW-1:0] x_nxt, line_x;
  logic          valid_nxt, line_valid;

  logic [XW-1:0] col;
  logic [1:0]    code;
  logic [23:0]   spr_rgb;

  always_ff @(posedge I_clk_pixel) begin
    if (I_wr_en) bitmap[I_wr_row] <= I_wr_data;
  end

  assign last_line = I_pixY == I_frameHeight - 1'b1;
  assign frame_end = (I_pixX == '0) && last_line;

  // A degenerate axis (screen narrower than the sprite) stays pinned at 0.
  always_comb begin
    pos_x_nxt = pos_x;
    neg_x_nxt = neg_x;
    if (MAX_X <= 0) begin
      pos_x_nxt = '0;
    end else if (!neg_x) begin
      if (pos_x >= XLIM) begin
        neg_x_nxt = 1'b1;
        pos_x_nxt = pos_x - 1'b1;
      end else begin
        pos_x_nxt = pos_x + 1'b1;
      end
    end else if (pos_x == '0) begin
      neg_x_nxt = 1'b0;
      pos_x_nxt = pos_x + 1'b1;
    end else begin
      pos_x_nxt = pos_x - 1'b1;
    end
  end

  always_comb begin
    pos_y_nxt = pos_y;
    neg_y_nxt = neg_y;
    if (MAX_Y <= 0) begin
      pos_y_nxt = '0;
    end else if (!neg_y) begin
      if (pos_y >= YLIM) begin
        neg_y_nxt = 1'b1;
        pos_y_nxt = pos_y - 1'b1;
      end else begin
        pos_y_nxt = pos_y + 1'b1;
      end
    end else if (pos_y == '0) begin
      neg_y_nxt = 1'b0;
      pos_y_nxt = pos_y + 1'b1;
    end else begin
      pos_y_nxt = pos_y - 1'b1;
    end
  end

  always_ff @(posedge I_clk_pixel) begin
    if (!I_reset_n) begin
      pos_x <= X0;
      pos_y <= Y0;
      neg_x <= 1'b0;
      neg_y <= 1'b0;
    end else if (frame_end) begin
      pos_x <= pos_x_nxt;
      pos_y <= pos_y_nxt;
      neg_x <= neg_x_nxt;
      neg_y <= neg_y_nxt;
    end
  end

  assign next_y   = last_line ? '0 : I_pixY + 1'b1;
  assign row_off  = next_y - pos_y;
  assign in_rng   = row_off[YW-1:4] == '0;
  assign fetch_go = I_pixX == I_frameWidth - 3'd4;
  assign line_end = I_pixX == I_frameWidth - 1'b1;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (fetch_go && in_rng) state_nxt = READ;
      READ:    state_nxt = LOAD;
      LOAD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge I_clk_pixel) begin
    if (!I_reset_n) begin
      state      <= IDLE;
      valid_nxt  <= 1'b0;
      line_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && fetch_go && !in_rng) valid_nxt <= 1'b0;
      if (state == LOAD) valid_nxt <= 1'b1;
      if (line_end) line_valid <= valid_nxt;
    end
  end

  // Read-first: a write landing on the fetch cycle is seen next frame.
  always_ff @(posedge I_clk_pixel) begin
    if (state == IDLE && fetch_go && in_rng) rd_data <= bitmap[row_off[3:0]];
    if (state == LOAD) begin
      bits_nxt <= rd_data;
      x_nxt    <= pos_x;
    end
    if (line_end) begin
      line_bits <= bits_nxt;
      line_x    <= x_nxt;
    end
  end

  assign col  = I_pixX - line_x;
  assign code = line_bits[{col[3:0], 1'b0} +: 2];

  always_comb begin
    spr_rgb = PAL3;
    unique case (code)
      2'd1:    spr_rgb = PAL1;
      2'd2:    spr_rgb = PAL2;
      default: spr_rgb = PAL3;
    endcase
  end

  always_ff @(posedge I_clk_pixel) begin
    if (!I_reset_n) begin
      O_rgb <= '0;
    end else if (line_valid && col[XW-1:4] == '0 && code != 2'd0) begin
      O_rgb <= spr_rgb;
    end else begin
      O_rgb <= I_rgb;
    end
  end

endmodule
